// File: rtl/imem_responder_if.sv
// Fetch-side bundle for the instruction memory responder: request channel,
// flush, program-load write port and response channel.
interface imem_responder_if #(
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          flush;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic [31:0]   resp_addr;
  logic          resp_err;

  // Fetch unit / program loader side.
  modport master (
    output req_valid, req_addr, flush, load_en, load_addr, load_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  // Instruction memory side.
  modport slave (
    input  req_valid, req_addr, flush, load_en, load_addr, load_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: synchronous word storage read through a
// single read-stage register, followed by a 2-entry response FIFO whose head
// drives the response channel. Misaligned fetches bypass storage and answer
// with an error flag and a NOP instruction. Flush and reset discard every
// in-flight and buffered fetch; storage contents are never reset.
module imem_responder #(
  parameter int          AW  = 10,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input logic             clk,
  input logic             reset,
  imem_responder_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  // Program storage (no reset: a loaded program must survive reset).
  logic [31:0]   mem_r [0:DEPTH-1];

  // Read stage.
  logic          rd_valid_r;
  logic [31:0]   rd_addr_r;
  logic [31:0]   rd_data_r;
  logic          rd_err_r;

  // Response FIFO (2 entries, 1-bit pointers).
  logic [31:0]   fifo_data_r [0:1];
  logic [31:0]   fifo_addr_r [0:1];
  logic          fifo_err_r  [0:1];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;

  // Handshake / control terms.
  logic [AW-1:0] rd_idx_s;
  logic          misaligned_s;
  logic [2:0]    outstanding_s;
  logic          resp_valid_s;
  logic          pop_s;
  logic          push_s;
  logic          req_ready_s;
  logic          accept_s;

  assign rd_idx_s      = bus.req_addr[AW+1:2];
  assign misaligned_s  = (bus.req_addr[1:0] != 2'b00);
  assign outstanding_s = {1'b0, count_r} + {2'b00, rd_valid_r};
  assign resp_valid_s  = (count_r != 2'd0) && !reset;
  assign pop_s         = resp_valid_s && bus.resp_ready;
  // The read stage always has room to move into the FIFO: req_ready never
  // lets outstanding exceed two, so a valid read stage implies count < 2
  // or a simultaneous pop.
  assign push_s        = rd_valid_r;
  assign accept_s      = bus.req_valid && req_ready_s;
  assign bus.req_ready = req_ready_s;
  assign bus.resp_valid = resp_valid_s;

  // Admit a request only when it cannot overflow the read stage + FIFO pair.
  always_comb begin
    req_ready_s = 1'b0;
    if (reset || bus.flush || bus.load_en) begin
      req_ready_s = 1'b0;
    end else if (outstanding_s < 3'd2) begin
      req_ready_s = 1'b1;
    end else if ((outstanding_s == 3'd2) && pop_s) begin
      req_ready_s = 1'b1;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  // Program-load write port; a read already captured keeps its old word.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem_r[bus.load_addr] <= bus.load_data;
    end
  end

  // Read stage: capture the word (or NOP on misalignment) for an accepted fetch.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd_valid_r <= 1'b0;
      rd_addr_r  <= 32'd0;
      rd_data_r  <= 32'd0;
      rd_err_r   <= 1'b0;
    end else begin
      rd_valid_r <= accept_s;
      if (accept_s) begin
        rd_addr_r <= bus.req_addr;
        if (misaligned_s) begin
          rd_data_r <= NOP;
          rd_err_r  <= 1'b1;
        end else begin
          rd_data_r <= mem_r[rd_idx_s];
          rd_err_r  <= 1'b0;
        end
      end
    end
  end

  // FIFO payload: written at the tail whenever the read stage moves forward.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= rd_data_r;
      fifo_addr_r[wr_ptr_r] <= rd_addr_r;
      fifo_err_r[wr_ptr_r]  <= rd_err_r;
    end
  end

  // FIFO pointers and occupancy; flush and reset empty it immediately.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Response channel shows the FIFO head, forced to zero when nothing is valid.
  always_comb begin
    bus.resp_data = 32'd0;
    bus.resp_addr = 32'd0;
    bus.resp_err  = 1'b0;
    if (resp_valid_s) begin
      bus.resp_data = fifo_data_r[rd_ptr_r];
      bus.resp_addr = fifo_addr_r[rd_ptr_r];
      bus.resp_err  = fifo_err_r[rd_ptr_r];
    end else begin
      bus.resp_data = 32'd0;
      bus.resp_addr = 32'd0;
      bus.resp_err  = 1'b0;
    end
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width (1024 x 32-bit words, byte address bits [AW+1:2]).
REQ-002 SHALL have parameter NOP, default 32'h00000013, instruction returned on error responses.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at rising edge.
REQ-007 SHALL have port req_addr  input  32  fetch byte address (PC).
REQ-008 SHALL have port flush  input  1  discard all in-flight and buffered fetches (taken branch).
REQ-009 SHALL have port load_en  input  1  program-load word write.
REQ-010 SHALL have port load_addr  input  AW  program-load word index.
REQ-011 SHALL have port load_data  input  32  program-load word.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  response consumed when resp_valid && resp_ready at rising edge.
REQ-014 SHALL have port resp_data  output  32  instruction word.
REQ-015 SHALL have port resp_addr  output  32  byte address of the request this response answers.
REQ-016 SHALL have port resp_err  output  1  misaligned request (req_addr[1:0] != 0).

Function
REQ-017 SHALL hold 2^AW x 32 storage, read synchronously through one read-stage register (rd_valid, rd_addr, rd_data, rd_err).
REQ-018 SHALL buffer responses in a 2-entry FIFO fed by the read stage; resp_* outputs SHALL be the FIFO head.
REQ-019 SHALL define outstanding = fifo_count + rd_valid; pop = resp_valid && resp_ready.
REQ-020 SHALL drive req_ready = !reset && !flush && !load_en && (outstanding < 2 || (outstanding == 2 && pop)).
REQ-021 SHALL, on an accepted request, index storage with req_addr[AW+1:2] (upper bits ignored) and set rd_valid at the next edge.
REQ-022 SHALL push the read stage into the FIFO on the edge after it becomes valid; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-023 SHALL give latency exactly 2 cycles: request accepted at edge N -> resp_valid high after edge N+1 (no backpressure).
REQ-024 SHALL sustain one response per cycle with resp_ready held high.
REQ-025 SHALL return responses in request order; never drop or duplicate except on flush/reset.
REQ-026 SHALL, for misaligned req_addr, return resp_err=1, resp_data=NOP, resp_addr=req_addr; storage is not consulted.
REQ-027 SHALL hold resp_data/resp_addr/resp_err stable while resp_valid && !resp_ready.
REQ-028 SHALL drive resp_data, resp_addr, resp_err to 0 whenever resp_valid=0.
REQ-029 SHALL, on flush, clear rd_valid and fifo_count at that edge; resp_valid low the following cycle; no request accepted in the flush cycle; a pop in the flush cycle is still a legal handshake.
REQ-030 SHALL write load_data to load_addr at the edge where load_en=1; a read already in the read stage keeps its captured data.
REQ-031 SHALL treat load_en and flush together as both taking effect.
REQ-032 SHALL never overflow the FIFO: req_ready guarantees outstanding <= 2 after every edge.

Reset
REQ-033 SHALL, while reset=1 at an edge, clear rd_valid, FIFO pointers and fifo_count; req_ready=0 and resp_valid=0 during reset.
REQ-034 SHALL NOT reset storage contents; loaded program survives reset.
REQ-035 SHALL discard any in-flight or buffered responses when reset asserts mid-operation; first post-reset response is for a request accepted after reset.

Verification
REQ-036 Load word 0=32'h00500093, word 1=32'h00A00113; requests 0x0,0x4 on consecutive cycles, resp_ready=1 -> responses 2 cycles after each, data 00500093 then 00A00113, resp_addr 0x0,0x4.
REQ-037 resp_ready=0, issue 3 back-to-back requests -> only 2 accepted, req_ready=0 on third; release resp_ready -> both drain in order, third then accepted.
REQ-038 Request 0x6 -> resp_err=1, resp_data=00000013, resp_addr=0x6.
REQ-039 Two responses buffered, assert flush one cycle -> resp_valid=0 next cycle, fifo empty; next request 0x8 returns word 2 only.
REQ-040 Stream 8 requests with resp_ready=1, assert reset at 4th response -> resp_valid=0 after edge, storage intact, post-reset request 0x0 returns 00500093.
REQ-041 load_en held with req_valid=1 -> req_ready=0; after load of word 3=32'hDEADBEEF, request 0xC returns DEADBEEF.
